binary_pool_stage: RTL



---
 rtl/binary_pool_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/binary_pool_stage.sv
// binary_pool_stage
//   Reads back the binary convolution output map from SRAM, applies a 2x2 stride-2 OR-pool
//   (binary max-pool) and writes the pooled rows to a separate SRAM region. One SRAM word
//   holds one feature-map row, bit j = column j. The SRAM read port has one cycle of latency.
//
// Ports
//   clk                     system clock, all logic on the rising edge
//   reset_b                 synchronous reset, active high
//   pool_run                start request, sampled only while idle
//   pool_busy               high from the cycle after accept through the DONE cycle
//   conv_rows / conv_cols   input map size R / C (0..16), latched on accept, >16 clamps to 16
//   pool_sram_read_address  read address, data returns on sram_pool_read_data next cycle
//   sram_pool_read_data     read data
//   pool_sram_write_address write address
//   pool_sram_write_data    write data
//   pool_sram_write_enable  one-cycle write strobe
module binary_pool_stage #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] IN_BASE  = 12'h000,
    parameter logic [ADDR_W-1:0] OUT_BASE = 12'h100
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              pool_run,
    output logic              pool_busy,
    input  logic [4:0]        conv_rows,
    input  logic [4:0]        conv_cols,
    output logic [ADDR_W-1:0] pool_sram_read_address,
    input  logic [DATA_W-1:0] sram_pool_read_data,
    output logic [ADDR_W-1:0] pool_sram_write_address,
    output logic [DATA_W-1:0] pool_sram_write_data,
    output logic              pool_sram_write_enable
);

    localparam int PoolW = int'(DATA_W / 2);

    typedef enum logic [2:0] {
        StIdle,
        StRda,
        StRdb,
        StCap,
        StWr,
        StDone
    } state_e;

    state_e            state_q;
    logic [3:0]        pr_q;     // pooled row count
    logic [3:0]        pc_q;     // pooled column count
    logic [3:0]        k_q;      // pooled row index
    logic [DATA_W-1:0] row_a_q;  // input row 2k

    logic [3:0]        pr_in;
    logic [3:0]        pc_in;
    logic [DATA_W-1:0] pooled;

    // Oversized dimensions clamp to 16, i.e. 8 pooled rows/columns; odd trailing row/col drops.
    always_comb begin
        pr_in = (conv_rows > 5'd16) ? 4'd8 : conv_rows[4:1];
        pc_in = (conv_cols > 5'd16) ? 4'd8 : conv_cols[4:1];
    end

    // Row 2k+1 is taken straight off the read bus in the CAP cycle so the write data register
    // is loaded on the same edge and the strobe lands in WR. Columns >= C can only sit at
    // j >= PC, so masking j >= PC also excludes them.
    always_comb begin
        pooled = '0;
        for (int j = 0; j < PoolW; j++) begin
            if (j < int'(pc_q)) begin
                pooled[j] = row_a_q[2*j] | row_a_q[2*j+1] |
                            sram_pool_read_data[2*j] | sram_pool_read_data[2*j+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q                 <= StIdle;
            pr_q                    <= '0;
            pc_q                    <= '0;
            k_q                     <= '0;
            row_a_q                 <= '0;
            pool_busy               <= 1'b0;
            pool_sram_read_address  <= '0;
            pool_sram_write_address <= '0;
            pool_sram_write_data    <= '0;
            pool_sram_write_enable  <= 1'b0;
        end else begin
            pool_sram_write_enable <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pool_run) begin
                        pr_q      <= pr_in;
                        pc_q      <= pc_in;
                        k_q       <= '0;
                        pool_busy <= 1'b1;
                        if (pr_in != 4'd0 && pc_in != 4'd0) begin
                            pool_sram_read_address <= IN_BASE;
                            state_q                <= StRda;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StRda: begin
                    pool_sram_read_address <= IN_BASE + ADDR_W'({k_q, 1'b1});
                    state_q                <= StRdb;
                end
                StRdb: begin
                    row_a_q <= sram_pool_read_data;
                    state_q <= StCap;
                end
                StCap: begin
                    pool_sram_write_enable  <= 1'b1;
                    pool_sram_write_address <= OUT_BASE + ADDR_W'(k_q);
                    pool_sram_write_data    <= pooled;
                    state_q                 <= StWr;
                end
                StWr: begin
                    k_q <= k_q + 4'd1;
                    if ((k_q + 4'd1) == pr_q) begin
                        state_q <= StDone;
                    end else begin
                        pool_sram_read_address <= IN_BASE + ADDR_W'({k_q + 4'd1, 1'b0});
                        state_q                <= StRda;
                    end
                end
                StDone: begin
                    pool_busy <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    pool_busy <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
